// File: rtl/z_deser_pkg.sv
// z_deser_pkg: shared types and sizing helpers for the Z deserializer.
//
// Optional feature macro: Z_DESER_PARITY_EN
//   When defined, each serial frame carries one trailing even-parity bit.
//
// Contents:
//   out_state_t  - output register occupancy (EMPTY / FULL)
//   PARITY_BITS  - extra bits per frame (0 or 1)
//   cnt_width()  - width of the bit counter for a given WIDTH
//   frame_bits() - serial bits per frame for a given WIDTH
package z_deser_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

`ifdef Z_DESER_PARITY_EN
    localparam int unsigned PARITY_BITS = 1;
`else
    localparam int unsigned PARITY_BITS = 0;
`endif

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    function automatic int unsigned frame_bits(input int unsigned width);
        return width + PARITY_BITS;
    endfunction

endpackage

// File: rtl/z_shift_collector.sv
// z_shift_collector: samples the serial Z stream and assembles frames.
//
// Optional feature macro: Z_DESER_PARITY_EN (adds word_perr output).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   z_in       in   serial data bit
//   z_valid    in   z_in is sampled on this edge when 1
//   clear      in   synchronous flush of the partial frame
//   word       out  assembled data word (valid while word_done=1)
//   word_done  out  this edge completes a frame
//   word_perr  out  parity mismatch for the completing frame (macro only)
module z_shift_collector
    import z_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z_in,
    input  logic             z_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] word,
    output logic             word_done
`ifdef Z_DESER_PARITY_EN
    ,
    output logic             word_perr
`endif
);

    localparam int unsigned FB  = frame_bits(WIDTH);
    // Only the bits before the completing one need storage; the last bit
    // is taken straight from z_in.
    localparam int unsigned SHW = FB - 1;
    localparam int unsigned CW  = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(FB - 1);

    logic [SHW-1:0] shreg_q, shreg_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [FB-1:0]  frame;

    always_comb begin
        // Stored bits joined with the incoming bit in arrival order.
        frame     = MSB_FIRST ? {shreg_q, z_in} : {z_in, shreg_q};
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        word_done = 1'b0;
        if (clear) begin
            shreg_d   = '0;
            bit_cnt_d = '0;
        end else if (z_valid) begin
            if (bit_cnt_q == LAST_CNT) begin
                shreg_d   = '0;
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                shreg_d   = MSB_FIRST ? frame[SHW-1:0] : frame[FB-1:1];
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

`ifdef Z_DESER_PARITY_EN
    // Data bits are fully stored; z_in is the parity bit.
    assign word      = shreg_q;
    assign word_perr = ^frame;
`else
    assign word      = frame;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/z_deserializer.sv
// z_deserializer: packs the serial Z stream into WIDTH-bit words and
// offers them on a valid/ready port. One word may wait in the output
// register while the next is being collected.
//
// Optional feature macro: Z_DESER_PARITY_EN (adds parity_err output;
// frames carry a trailing even-parity bit).
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   z_in       in   serial bit
//   z_valid    in   sample z_in on this edge
//   clear      in   discard the partial word (output register untouched)
//   out_data   out  assembled word
//   out_valid  out  out_data holds an unconsumed word
//   out_ready  in   consumer accepts when out_valid && out_ready
//   overrun    out  one-cycle pulse: a completed word was dropped
//   parity_err out  parity flag loaded with out_data (macro only)
module z_deserializer
    import z_deser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             z_in,
    input  logic             z_valid,
    input  logic             clear,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
`ifdef Z_DESER_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             word_perr;

    out_state_t       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             overrun_q, overrun_d;
    logic             perr_q, perr_d;
    logic             load;

    z_shift_collector #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_collector (
        .clk       (clk),
        .reset     (reset),
        .z_in      (z_in),
        .z_valid   (z_valid),
        .clear     (clear),
        .word      (word),
        .word_done (word_done)
`ifdef Z_DESER_PARITY_EN
        ,
        .word_perr (word_perr)
`endif
    );

`ifndef Z_DESER_PARITY_EN
    assign word_perr = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        perr_d    = perr_q;
        overrun_d = 1'b0;
        load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (word_done) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (word_done) begin
                    // Same-edge accept and completion swaps words without a bubble.
                    if (out_ready) load = 1'b1;
                    else           overrun_d = 1'b1;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load) begin
            data_d = word;
            perr_d = word_perr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            data_q    <= '0;
            perr_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            perr_q    <= perr_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == FULL);
    assign overrun   = overrun_q;
`ifdef Z_DESER_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_z_deserializer.sv
// Bench for z_deserializer (WIDTH=8, MSB_FIRST=1). Expected words are
// queued by the stimulus; a negedge monitor pops them on every handshake.
module tb_z_deserializer;

`ifdef Z_DESER_PARITY_EN
    localparam int FB = 9;
`else
    localparam int FB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       z_in = 1'b0;
    logic       z_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       overrun;
    logic       perr_obs;
`ifdef Z_DESER_PARITY_EN
    logic       parity_err;
    assign perr_obs = parity_err;
`else
    assign perr_obs = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ov_cnt   = 0;
    logic [8:0] sb[$];
    logic       hold_prev = 1'b0;
    logic [7:0] prev_data = '0;

    z_deserializer #(
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .z_in      (z_in),
        .z_valid   (z_valid),
        .clear     (clear),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
`ifdef Z_DESER_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        z_valid = 1'b1;
        z_in    = b;
        tick();
        z_valid = 1'b0;
        z_in    = 1'b0;
    endtask

    // Sends one frame MSB first (plus parity bit when enabled). bad_par
    // inverts the parity bit; rdy_last raises out_ready with the last bit.
    task automatic send_word(input logic [7:0] w, input bit gaps, input bit push,
                             input bit rdy_last, input bit bad_par);
        logic b;
        if (push) sb.push_back({w, bad_par});
        for (int k = 0; k < FB; k++) begin
            b = (k < 8) ? w[7-k] : ((^w) ^ bad_par);
            if (k == FB - 1 && rdy_last) out_ready = 1'b1;
            send_bit(b);
            if (gaps && k != FB - 1) tick();
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [8:0] exp;
        if (reset) begin
            if (hold_prev) begin
                n_checks++;
                if (out_data !== prev_data) begin
                    n_fail++;
                    $display("FAIL hold_stable: got %h expected %h", out_data, prev_data);
                end
            end
            if (overrun) ov_cnt++;
            if (out_valid && out_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else begin
                    exp = sb.pop_front();
                    if ({out_data, perr_obs} !== exp) begin
                        n_fail++;
                        $display("FAIL word: got %h/%b expected %h/%b",
                                 out_data, perr_obs, exp[8:1], exp[0]);
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
        end else begin
            hold_prev = 1'b0;
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset = 1'b1;
        tick();

        // Back-to-back bits, latency 1, single-cycle valid
        out_ready = 1'b1;
        send_word(8'hB2, 1'b0, 1'b1, 1'b0, 1'b0);
        check("lat_valid_rise", 32'(out_valid), 32'd1);
        tick();
        check("lat_valid_fall", 32'(out_valid), 32'd0);

        // Gapped input
        send_word(8'hB2, 1'b1, 1'b1, 1'b0, 1'b0);
        check("gap_valid_rise", 32'(out_valid), 32'd1);
        tick();

        // Overrun: second word dropped
        out_ready = 1'b0;
        send_word(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ovr_full", 32'(out_valid), 32'd1);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_keep", 32'(out_data), 32'hA5);
        tick();
        check("ovr_pulse_end", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        tick();
        check("ovr_drain", 32'(out_valid), 32'd0);

        // Accept and complete on the same edge
        out_ready = 1'b0;
        send_word(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        send_word(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        check("swap_valid", 32'(out_valid), 32'd1);
        check("swap_data", 32'(out_data), 32'h22);
        check("swap_no_ovr", 32'(overrun), 32'd0);
        tick();

        // clear mid-word, with a z_valid bit that must be ignored
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        clear = 1'b1; z_valid = 1'b1; z_in = 1'b1;
        tick();
        clear = 1'b0; z_valid = 1'b0; z_in = 1'b0;
        send_word(8'h0F, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // clear on the completing edge produces no word
        for (int i = 0; i < FB - 1; i++) send_bit(1'b1);
        clear = 1'b1; z_valid = 1'b1; z_in = 1'b1;
        tick();
        clear = 1'b0; z_valid = 1'b0;
        check("clear_complete_none", 32'(out_valid), 32'd0);
        send_word(8'hC3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Async reset with a held word and a partial word
        out_ready = 1'b0;
        send_word(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        #2 reset = 1'b0;
        #1;
        check("areset_valid", 32'(out_valid), 32'd0);
        check("areset_data", 32'(out_data), 32'd0);
        check("areset_overrun", 32'(overrun), 32'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        send_word(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("post_reset_data", 32'(out_data), 32'h5A);
        tick();

`ifdef Z_DESER_PARITY_EN
        send_word(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
        check("par_ok", 32'(parity_err), 32'd0);
        tick();
        send_word(8'h03, 1'b0, 1'b1, 1'b0, 1'b1);
        check("par_err", 32'(parity_err), 32'd1);
        check("par_err_data", 32'(out_data), 32'h03);
        tick();
`endif

        repeat (4) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("overrun_count", 32'(ov_cnt), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
